// File: rtl/proc_test_sequencer_pkg.sv
// Shared types for the processor test sequencer: FSM state encoding and counter width.
package proc_test_sequencer_pkg;

  // Width of the cycle counters (cycles_run and the RUN budget).
  localparam int unsigned CntW = 32;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StLoad  = 3'd1,
    StRst   = 3'd2,
    StRun   = 3'd3,
    StCheck = 3'd4,
    StDone  = 3'd5
  } seq_state_e;

endpackage

// File: rtl/proc_test_sequencer_sat_counter.sv
// Up-counter with synchronous clear and enable that sticks at its all-ones value.
module proc_test_sequencer_sat_counter #(
  parameter int unsigned Width = 32
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             clear_i,
  input  logic             en_i,
  output logic [Width-1:0] count_o
);

  logic [Width-1:0] count_q;

  // Count enabled cycles; clear wins over enable, saturate at all ones.
  always_ff @(posedge clk_i) begin
    if (reset_i || clear_i) begin
      count_q <= '0;
    end else if (en_i && (count_q != {Width{1'b1}})) begin
      count_q <= count_q + Width'(1);
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/proc_test_sequencer.sv
// Run controller: loads a program into imem, pulses processor reset, runs for a budget or until
// halt, then scans the GPR file against an expected-value ROM and reports pass/fail.
module proc_test_sequencer
  import proc_test_sequencer_pkg::*;
#(
  parameter int unsigned DataW       = 32,
  parameter int unsigned NRegs       = 32,
  parameter int unsigned ProgAw      = 6,
  parameter int unsigned ResetCycles = 2,
  parameter int unsigned RunCycles   = 100,
  parameter bit          StopOnFail  = 1'b1,
  localparam int unsigned RegAw      = $clog2(NRegs)
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              start_i,
  input  logic [ProgAw:0]   prog_len_i,
  output logic [ProgAw-1:0] prog_addr_o,
  input  logic [DataW-1:0]  prog_rdata_i,
  output logic              imem_we_o,
  output logic [ProgAw-1:0] imem_waddr_o,
  output logic [DataW-1:0]  imem_wdata_o,
  output logic              proc_reset_o,
  input  logic              proc_halt_i,
  output logic [RegAw-1:0]  dbg_raddr_o,
  input  logic [DataW-1:0]  dbg_rdata_i,
  output logic [RegAw-1:0]  exp_addr_o,
  input  logic [DataW-1:0]  exp_rdata_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              pass_o,
  output logic [RegAw-1:0]  fail_idx_o,
  output logic [DataW-1:0]  fail_got_o,
  output logic [DataW-1:0]  fail_exp_o,
  output logic [CntW-1:0]   cycles_run_o
);

  localparam logic [RegAw-1:0] RegFirst = RegAw'(1);
  localparam logic [RegAw-1:0] RegLast  = RegAw'(NRegs - 1);

  seq_state_e        state_q;
  logic [ProgAw-1:0] prog_last_q, prog_addr_q, imem_waddr_q;
  logic              imem_we_q, proc_reset_q, busy_q, done_q, pass_q;
  logic              fail_seen_q, cmp_valid_q;
  logic [CntW-1:0]   rst_cnt_q;
  logic [RegAw-1:0]  raddr_q, cmp_idx_q, fail_idx_q;
  logic [DataW-1:0]  got_q, fail_got_q, fail_exp_q;
  logic [CntW-1:0]   cycles_run, run_cnt;
  logic              start_ok, in_run, budget_hit, mismatch, last_write;

  assign start_ok   = start_i && ((state_q == StIdle) || (state_q == StDone));
  assign in_run     = (state_q == StRun);
  assign budget_hit = (run_cnt == CntW'(RunCycles - 1));
  assign mismatch   = cmp_valid_q && (got_q != exp_rdata_i);
  assign last_write = imem_we_q && (imem_waddr_q == prog_last_q);

  // Total cycles spent in RUN for this sequence; cleared by an accepted start.
  proc_test_sequencer_sat_counter #(
    .Width(CntW)
  ) u_cycles_cnt (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .clear_i(start_ok),
    .en_i   (in_run),
    .count_o(cycles_run)
  );

  // RUN budget: value equals the number of RUN cycles already completed.
  proc_test_sequencer_sat_counter #(
    .Width(CntW)
  ) u_budget_cnt (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .clear_i(!in_run),
    .en_i   (in_run),
    .count_o(run_cnt)
  );

  // Sequencer FSM with LOAD address pipeline and pipelined CHECK scan.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= StIdle;
      prog_last_q  <= '0;
      prog_addr_q  <= '0;
      imem_we_q    <= 1'b0;
      imem_waddr_q <= '0;
      proc_reset_q <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      fail_seen_q  <= 1'b0;
      cmp_valid_q  <= 1'b0;
      rst_cnt_q    <= '0;
      raddr_q      <= '0;
      cmp_idx_q    <= '0;
      got_q        <= '0;
      fail_idx_q   <= '0;
      fail_got_q   <= '0;
      fail_exp_q   <= '0;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          if (start_i) begin
            busy_q      <= 1'b1;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            fail_seen_q <= 1'b0;
            fail_idx_q  <= '0;
            fail_got_q  <= '0;
            fail_exp_q  <= '0;
            cmp_valid_q <= 1'b0;
            prog_addr_q <= '0;
            rst_cnt_q   <= '0;
            prog_last_q <= ProgAw'(prog_len_i - (ProgAw + 1)'(1));
            state_q     <= (prog_len_i != '0) ? StLoad : StRst;
          end
        end
        StLoad: begin
          if (last_write) begin
            imem_we_q   <= 1'b0;
            prog_addr_q <= '0;
            rst_cnt_q   <= '0;
            state_q     <= StRst;
          end else begin
            // ROM has one cycle of latency, so the write trails the address by a cycle.
            imem_we_q    <= 1'b1;
            imem_waddr_q <= prog_addr_q;
            if (prog_addr_q != prog_last_q) begin
              prog_addr_q <= prog_addr_q + ProgAw'(1);
            end
          end
        end
        StRst: begin
          if (rst_cnt_q == CntW'(ResetCycles - 1)) begin
            proc_reset_q <= 1'b0;
            state_q      <= StRun;
          end else begin
            rst_cnt_q <= rst_cnt_q + CntW'(1);
          end
        end
        StRun: begin
          if (proc_halt_i || budget_hit) begin
            raddr_q     <= RegFirst;
            cmp_valid_q <= 1'b0;
            state_q     <= StCheck;
          end
        end
        StCheck: begin
          cmp_valid_q <= 1'b1;
          cmp_idx_q   <= raddr_q;
          got_q       <= dbg_rdata_i;
          if (raddr_q != RegLast) begin
            raddr_q <= raddr_q + RegAw'(1);
          end
          if (mismatch && !fail_seen_q) begin
            fail_seen_q <= 1'b1;
            fail_idx_q  <= cmp_idx_q;
            fail_got_q  <= got_q;
            fail_exp_q  <= exp_rdata_i;
          end
          if ((mismatch && StopOnFail) || (cmp_valid_q && (cmp_idx_q == RegLast))) begin
            cmp_valid_q  <= 1'b0;
            raddr_q      <= '0;
            proc_reset_q <= 1'b1;
            busy_q       <= 1'b0;
            done_q       <= 1'b1;
            pass_q       <= !(fail_seen_q || mismatch);
            state_q      <= StDone;
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign prog_addr_o  = prog_addr_q;
  assign imem_we_o    = imem_we_q;
  assign imem_waddr_o = imem_waddr_q;
  assign imem_wdata_o = prog_rdata_i;
  assign proc_reset_o = proc_reset_q;
  assign dbg_raddr_o  = raddr_q;
  assign exp_addr_o   = raddr_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign pass_o       = pass_q;
  assign fail_idx_o   = fail_idx_q;
  assign fail_got_o   = fail_got_q;
  assign fail_exp_o   = fail_exp_q;
  assign cycles_run_o = cycles_run;

endmodule

// File: tb/tb_proc_test_sequencer.sv
// Directed bench: two sequencers (stop-on-fail and full-scan) share stimulus and memory models.
module tb_proc_test_sequencer;

  logic        clk = 1'b0;
  logic        reset, start, halt;
  logic [6:0]  prog_len;

  logic [31:0] prog_rom [64];
  logic [31:0] gpr      [32];
  logic [31:0] exp_rom  [32];

  logic [5:0]  a_prog_addr, a_waddr, b_prog_addr, b_waddr;
  logic [31:0] a_prog_rdata, a_wdata, b_prog_rdata, b_wdata;
  logic        a_we, a_preset, a_busy, a_done, a_pass;
  logic        b_we, b_preset, b_busy, b_done, b_pass;
  logic [4:0]  a_raddr, a_eaddr, a_fidx, b_raddr, b_eaddr, b_fidx;
  logic [31:0] a_dbg, a_exp, a_fgot, a_fexp, a_cyc;
  logic [31:0] b_dbg, b_exp, b_fgot, b_fexp, b_cyc;

  int checks = 0;
  int errors = 0;

  int nwr, wr_bad, first_we, last_we, first_low, nlow, a_done_at, b_done_at;
  int halt_n;
  logic [4:0] raddr_at_halt, raddr_after_halt;

  always #5 clk = ~clk;

  // Registered ROM reads and combinational GPR debug port for each DUT.
  always @(posedge clk) begin
    a_prog_rdata <= prog_rom[a_prog_addr];
    b_prog_rdata <= prog_rom[b_prog_addr];
    a_exp        <= exp_rom[a_eaddr];
    b_exp        <= exp_rom[b_eaddr];
  end
  assign a_dbg = gpr[a_raddr];
  assign b_dbg = gpr[b_raddr];

  proc_test_sequencer #(.StopOnFail(1'b1)) dut_a (
    .clk_i(clk), .reset_i(reset), .start_i(start), .prog_len_i(prog_len),
    .prog_addr_o(a_prog_addr), .prog_rdata_i(a_prog_rdata),
    .imem_we_o(a_we), .imem_waddr_o(a_waddr), .imem_wdata_o(a_wdata),
    .proc_reset_o(a_preset), .proc_halt_i(halt),
    .dbg_raddr_o(a_raddr), .dbg_rdata_i(a_dbg), .exp_addr_o(a_eaddr), .exp_rdata_i(a_exp),
    .busy_o(a_busy), .done_o(a_done), .pass_o(a_pass),
    .fail_idx_o(a_fidx), .fail_got_o(a_fgot), .fail_exp_o(a_fexp), .cycles_run_o(a_cyc)
  );

  proc_test_sequencer #(.StopOnFail(1'b0)) dut_b (
    .clk_i(clk), .reset_i(reset), .start_i(start), .prog_len_i(prog_len),
    .prog_addr_o(b_prog_addr), .prog_rdata_i(b_prog_rdata),
    .imem_we_o(b_we), .imem_waddr_o(b_waddr), .imem_wdata_o(b_wdata),
    .proc_reset_o(b_preset), .proc_halt_i(halt),
    .dbg_raddr_o(b_raddr), .dbg_rdata_i(b_dbg), .exp_addr_o(b_eaddr), .exp_rdata_i(b_exp),
    .busy_o(b_busy), .done_o(b_done), .pass_o(b_pass),
    .fail_idx_o(b_fidx), .fail_got_o(b_fgot), .fail_exp_o(b_fexp), .cycles_run_o(b_cyc)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // Start a sequence and observe it sample-by-sample (negedge n = 1, 2, ...) until both finish.
  task automatic run_seq(input int len, input int halt_k, input int poke_n);
    int n;
    nwr = 0; wr_bad = 0; first_we = -1; last_we = -1; first_low = -1; nlow = 0;
    a_done_at = -1; b_done_at = -1; halt_n = -1;
    raddr_at_halt = 'x; raddr_after_halt = 'x;
    start = 1'b1;
    prog_len = 7'(len);
    n = 0;
    while (n < 400 && !(a_done_at >= 0 && b_done_at >= 0)) begin
      @(negedge clk);
      n++;
      if (a_we) begin
        if (first_we < 0) first_we = n;
        last_we = n;
        if (a_waddr !== 6'(nwr) || a_wdata !== prog_rom[nwr]) wr_bad++;
        nwr++;
      end
      if (!a_preset) begin
        if (first_low < 0) first_low = n;
        nlow++;
      end
      if (a_done && a_done_at < 0) a_done_at = n;
      if (b_done && b_done_at < 0) b_done_at = n;
      if (n == halt_n) raddr_at_halt = a_raddr;
      if (halt_n >= 0 && n == halt_n + 1) raddr_after_halt = a_raddr;
      halt = 1'b0;
      if (halt_k > 0 && first_low >= 0 && !a_preset && (n - first_low + 1) == halt_k) begin
        halt = 1'b1;
        halt_n = n;
        raddr_at_halt = a_raddr;
      end
      start = (n == poke_n);
    end
    start = 1'b0;
    halt  = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) prog_rom[i] = 32'h2001_0005 + 32'(i);
    for (int i = 0; i < 32; i++) begin
      gpr[i]     = 32'h0000_1000 + 32'(i * 7);
      exp_rom[i] = gpr[i];
    end
    reset = 1'b1; start = 1'b0; halt = 1'b0; prog_len = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Reset state.
    chk("rst_proc_reset", 32'(a_preset), 32'd1);
    chk("rst_imem_we",    32'(a_we),     32'd0);
    chk("rst_busy",       32'(a_busy),   32'd0);
    chk("rst_done",       32'(a_done),   32'd0);
    chk("rst_pass",       32'(a_pass),   32'd0);
    chk("rst_fail_idx",   32'(a_fidx),   32'd0);
    chk("rst_cycles_run", a_cyc,         32'd0);
    chk("rst_prog_addr",  32'(a_prog_addr), 32'd0);
    chk("rst_dbg_raddr",  32'(a_raddr),  32'd0);

    // Load 13 words, full 100-cycle budget, all registers match; start during RUN ignored.
    run_seq(13, 0, 50);
    chk("t1_nwrites",    32'(nwr),       32'd13);
    chk("t1_write_data", 32'(wr_bad),    32'd0);
    chk("t1_first_we",   32'(first_we),  32'd2);
    chk("t1_last_we",    32'(last_we),   32'd14);
    chk("t1_first_low",  32'(first_low), 32'd17);
    chk("t1_low_cycles", 32'(nlow),      32'd132);
    chk("t1_cycles_run", a_cyc,          32'd100);
    chk("t1_a_done_at",  32'(a_done_at), 32'd149);
    chk("t1_b_done_at",  32'(b_done_at), 32'd149);
    chk("t1_pass",       32'(a_pass),    32'd1);
    chk("t1_busy",       32'(a_busy),    32'd0);
    chk("t1_b_pass",     32'(b_pass),    32'd1);
    chk("t1_done_preset", 32'(a_preset), 32'd1);

    // No load, halt in the 17th RUN cycle.
    run_seq(0, 17, 0);
    chk("t3_nwrites",     32'(nwr),              32'd0);
    chk("t3_first_low",   32'(first_low),        32'd3);
    chk("t3_raddr_halt",  32'(raddr_at_halt),    32'd0);
    chk("t3_raddr_check", 32'(raddr_after_halt), 32'd1);
    chk("t3_cycles_run",  a_cyc,                 32'd17);
    chk("t3_low_cycles",  32'(nlow),             32'd49);
    chk("t3_done_at",     32'(a_done_at),        32'd52);
    chk("t3_pass",        32'(a_pass),           32'd1);

    // Registers 7 and 9 wrong; both variants must report register 7.
    gpr[7]     = 32'hCAFE_BABE;
    exp_rom[7] = 32'h0000_0005;
    gpr[9]     = 32'h1234_5678;
    run_seq(0, 0, 0);
    chk("t5_a_fail_idx", 32'(a_fidx),    32'd7);
    chk("t5_a_fail_got", a_fgot,         32'hCAFE_BABE);
    chk("t5_a_fail_exp", a_fexp,         32'h0000_0005);
    chk("t5_a_pass",     32'(a_pass),    32'd0);
    chk("t5_a_done_at",  32'(a_done_at), 32'd111);
    chk("t5_b_fail_idx", 32'(b_fidx),    32'd7);
    chk("t5_b_fail_got", b_fgot,         32'hCAFE_BABE);
    chk("t5_b_fail_exp", b_fexp,         32'h0000_0005);
    chk("t5_b_pass",     32'(b_pass),    32'd0);
    chk("t5_b_done_at",  32'(b_done_at), 32'd135);
    chk("t5_cycles_run", a_cyc,          32'd100);
    gpr[7] = 32'h0000_1000 + 32'd49; exp_rom[7] = gpr[7];
    gpr[9] = exp_rom[9];

    // Reset during LOAD while word 3 is written and word 4 is in flight.
    start = 1'b1; prog_len = 7'd13;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    chk("t6_mid_we",    32'(a_we),    32'd1);
    chk("t6_mid_waddr", 32'(a_waddr), 32'd3);
    reset = 1'b1;
    @(negedge clk);
    chk("t6_rst_we",     32'(a_we),        32'd0);
    chk("t6_rst_preset", 32'(a_preset),    32'd1);
    chk("t6_rst_busy",   32'(a_busy),      32'd0);
    chk("t6_rst_paddr",  32'(a_prog_addr), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    run_seq(13, 0, 0);
    chk("t6_nwrites",    32'(nwr),      32'd13);
    chk("t6_write_data", 32'(wr_bad),   32'd0);
    chk("t6_first_we",   32'(first_we), 32'd2);
    chk("t6_pass",       32'(a_pass),   32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
